// File: rtl/spi_rd_responder.sv
// SPI target for the r200 read link: decodes a 73-bit frame into one 32-bit WB-style bus access.
// Optional feature: define SPI_WRITE_EN to accept cmd 0x02 frames as bus writes.
module spi_rd_responder #(
    parameter logic [15:0] ADDR_HI     = 16'h8000,
    parameter int          SYNC_STAGES = 2,
    parameter logic        IDLE_MISO   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        sck,
    input  logic        mosi,
    output logic        miso,
    output logic        o_stb,
    output logic        o_we,
    output logic [31:0] o_addr,
    output logic [31:0] o_data,
    input  logic [31:0] i_data,
    input  logic        i_ack,
    output logic        o_busy,
    output logic        o_err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEAD   = 3'd1,
        ST_CMD    = 3'd2,
        ST_ADDR   = 3'd3,
        ST_RD     = 3'd4,
        ST_WR     = 3'd5,
        ST_IGNORE = 3'd6
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync_r, sck_sync_r, mosi_sync_r;
    logic        cs_d_r, sck_d_r;
    state_t      state_r;
    logic [6:0]  bit_cnt_r;
    logic [38:0] rx_r;
    logic [31:0] tx_r;
    logic        tx_loaded_r, miso_r, err_r;
    logic        o_stb_r, o_we_r, o_busy_r, cur_rd_r;
    logic [31:0] o_addr_r, o_data_r;
    logic        pend_r, pend_we_r, pend_rd_r;
    logic [31:0] pend_addr_r, pend_data_r;
`ifdef SPI_WRITE_EN
    logic [31:0] addr_r;
    logic [30:0] wdata_r;
`endif

    logic        cs_s, sck_s, mosi_s, cs_rise_s, cs_fall_s, sck_rise_s, sck_fall_s;
    logic [39:0] rx_next_s;
    logic        at_decode_s, addr_hit_s, dec_rd_s, dec_wr_s, wr_done_s;
    logic        rd_fall_s, late_s, rd_capture_s, decoding_s;
    logic [31:0] wr_data_s, wr_addr_s;

    // Input synchronizers and edge-detect history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_sync_r   <= '0;
            sck_sync_r  <= '0;
            mosi_sync_r <= '0;
            cs_d_r      <= 1'b0;
            sck_d_r     <= 1'b0;
        end else begin
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs};
            sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], sck};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
            cs_d_r      <= cs_sync_r[SYNC_STAGES-1];
            sck_d_r     <= sck_sync_r[SYNC_STAGES-1];
        end
    end

    // Edge strobes and frame decode conditions.
    always_comb begin
        cs_s         = cs_sync_r[SYNC_STAGES-1];
        sck_s        = sck_sync_r[SYNC_STAGES-1];
        mosi_s       = mosi_sync_r[SYNC_STAGES-1];
        cs_rise_s    = cs_s & ~cs_d_r;
        cs_fall_s    = ~cs_s & cs_d_r;
        sck_rise_s   = sck_s & ~sck_d_r & cs_s;
        sck_fall_s   = ~sck_s & sck_d_r & cs_s;
        rx_next_s    = {rx_r, mosi_s};
        at_decode_s  = (state_r == ST_ADDR) && sck_rise_s && (bit_cnt_r == 7'd40);
        addr_hit_s   = (rx_next_s[31:16] == ADDR_HI);
        dec_rd_s     = at_decode_s && (rx_next_s[39:32] == 8'h03) && addr_hit_s;
`ifdef SPI_WRITE_EN
        dec_wr_s     = at_decode_s && (rx_next_s[39:32] == 8'h02) && addr_hit_s;
        wr_done_s    = (state_r == ST_WR) && sck_rise_s && (bit_cnt_r == 7'd72);
        wr_data_s    = {wdata_r, mosi_s};
        wr_addr_s    = addr_r;
`else
        dec_wr_s     = 1'b0;
        wr_done_s    = 1'b0;
        wr_data_s    = 32'h0;
        wr_addr_s    = 32'h0;
`endif
        // Data bit k is presented on the fall following rise k-1 (counts 41..72).
        rd_fall_s    = (state_r == ST_RD) && sck_fall_s &&
                       (bit_cnt_r >= 7'd41) && (bit_cnt_r <= 7'd72);
        late_s       = rd_fall_s && (bit_cnt_r == 7'd41) && !tx_loaded_r;
        rd_capture_s = i_ack && o_stb_r && cur_rd_r && !late_s;
        decoding_s   = (state_r == ST_LEAD) || (state_r == ST_CMD) ||
                       (state_r == ST_ADDR) || (state_r == ST_WR);
    end

    // Frame FSM, bit counter, shift registers, miso and error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 7'd0;
            rx_r        <= 39'h0;
            tx_r        <= 32'h0;
            tx_loaded_r <= 1'b0;
            miso_r      <= IDLE_MISO;
            err_r       <= 1'b0;
`ifdef SPI_WRITE_EN
            addr_r      <= 32'h0;
            wdata_r     <= 31'h0;
`endif
        end else begin
            err_r <= 1'b0;
            if (cs_rise_s)
                bit_cnt_r <= 7'd0;
            else if (sck_rise_s && (bit_cnt_r < 7'd73))
                bit_cnt_r <= bit_cnt_r + 7'd1;
            if (sck_rise_s && (bit_cnt_r <= 7'd40))
                rx_r <= rx_next_s[38:0];
            if (rd_capture_s) begin
                tx_r        <= i_data;
                tx_loaded_r <= 1'b1;
            end
`ifdef SPI_WRITE_EN
            if (dec_wr_s)
                addr_r <= rx_next_s[31:0];
            if ((state_r == ST_WR) && sck_rise_s)
                wdata_r <= wr_data_s[30:0];
`endif
            if (cs_fall_s) begin
                state_r <= ST_IDLE;
                miso_r  <= IDLE_MISO;
            end else if (cs_rise_s) begin
                state_r     <= ST_LEAD;
                tx_loaded_r <= 1'b0;
                miso_r      <= IDLE_MISO;
            end else begin
                case (state_r)
                    ST_IDLE:   miso_r <= IDLE_MISO;
                    ST_LEAD:   if (sck_rise_s) state_r <= ST_CMD;
                    ST_CMD:    if (sck_rise_s && (bit_cnt_r == 7'd8)) state_r <= ST_ADDR;
                    ST_ADDR: begin
                        if (dec_rd_s)
                            state_r <= ST_RD;
                        else if (dec_wr_s)
                            state_r <= ST_WR;
                        else if (at_decode_s) begin
                            state_r <= ST_IGNORE;
                            err_r   <= 1'b1;
                        end
                    end
                    ST_RD: begin
                        if (late_s) begin
                            miso_r      <= 1'b0;
                            tx_r        <= 32'h0;
                            tx_loaded_r <= 1'b1;
                            err_r       <= 1'b1;
                        end else if (rd_fall_s) begin
                            miso_r <= tx_r[31];
                            tx_r   <= {tx_r[30:0], 1'b0};
                        end else if (sck_fall_s && (bit_cnt_r >= 7'd73))
                            miso_r <= IDLE_MISO;
                    end
                    ST_WR:     if (wr_done_s) state_r <= ST_IGNORE;
                    ST_IGNORE: miso_r <= IDLE_MISO;
                    default:   state_r <= ST_IDLE;
                endcase
            end
        end
    end

    // Bus side: one pending slot so a new frame's access waits for the prior ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_stb_r     <= 1'b0;
            o_we_r      <= 1'b0;
            o_addr_r    <= 32'h0;
            o_data_r    <= 32'h0;
            o_busy_r    <= 1'b0;
            cur_rd_r    <= 1'b0;
            pend_r      <= 1'b0;
            pend_we_r   <= 1'b0;
            pend_rd_r   <= 1'b0;
            pend_addr_r <= 32'h0;
            pend_data_r <= 32'h0;
        end else begin
            if (!o_stb_r || i_ack) begin
                if (pend_r) begin
                    o_stb_r  <= 1'b1;
                    o_addr_r <= pend_addr_r;
                    o_we_r   <= pend_we_r;
                    o_data_r <= pend_data_r;
                    cur_rd_r <= pend_rd_r;
                    pend_r   <= 1'b0;
                end else begin
                    o_stb_r  <= 1'b0;
                    cur_rd_r <= 1'b0;
                end
            end
            if (dec_rd_s) begin
                pend_r      <= 1'b1;
                pend_addr_r <= rx_next_s[31:0];
                pend_we_r   <= 1'b0;
                pend_data_r <= 32'h0;
                pend_rd_r   <= 1'b1;
            end else if (wr_done_s) begin
                pend_r      <= 1'b1;
                pend_addr_r <= wr_addr_s;
                pend_we_r   <= 1'b1;
                pend_data_r <= wr_data_s;
                pend_rd_r   <= 1'b0;
            end
            // Read data nobody is waiting for any more is dropped on arrival.
            if (late_s || cs_fall_s) begin
                pend_rd_r <= 1'b0;
                cur_rd_r  <= 1'b0;
            end
            o_busy_r <= decoding_s | o_stb_r | pend_r;
        end
    end

    assign miso   = miso_r;
    assign o_stb  = o_stb_r;
    assign o_we   = o_we_r;
    assign o_addr = o_addr_r;
    assign o_data = o_data_r;
    assign o_busy = o_busy_r;
    assign o_err  = err_r;

endmodule

// File: tb/tb_spi_rd_responder.sv
// Directed bench for spi_rd_responder: SPI master model, bus responder and scoreboard queues.
module tb_spi_rd_responder;

    localparam int HALF = 10;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst, cs, sck, mosi, miso;
    logic        o_stb, o_we, o_busy, o_err, i_ack;
    logic [31:0] o_addr, o_data, i_data;

    bus_t        exp_bus_q[$];
    logic [31:0] exp_miso_q[$];
    int          n_cmp = 0, n_bad = 0, err_cnt = 0, ack_cnt = 0, ack_dly = 2;
    logic [31:0] rd_data = 32'h0;
    bit          chk_busy = 1'b0;

    always #5 clk = ~clk;

    spi_rd_responder dut (
        .clk(clk), .rst(rst), .cs(cs), .sck(sck), .mosi(mosi), .miso(miso),
        .o_stb(o_stb), .o_we(o_we), .o_addr(o_addr), .o_data(o_data),
        .i_data(i_data), .i_ack(i_ack), .o_busy(o_busy), .o_err(o_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic m);
        mosi = b;
        repeat (HALF) @(negedge clk);
        m = miso;
        sck = 1'b1;
        repeat (HALF) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                         input int nbits, input bit keep_cs, output logic [31:0] rdat);
        logic [72:0] fr;
        logic        m;
        fr   = {1'b1, cmd, addr, data};
        rdat = 32'h0;
        cs   = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_bit(fr[72-i], m);
            if (i >= 41) rdat = {rdat[30:0], m};
        end
        if (!keep_cs) begin
            repeat (HALF) @(negedge clk);
            cs   = 1'b0;
            mosi = 1'b0;
            repeat (12) @(negedge clk);
        end
    endtask

    // o_err pulse counter
    initial forever begin
        @(negedge clk);
        if (o_err === 1'b1) err_cnt++;
    end

    // Bus responder: checks each request against the scoreboard, then acks after ack_dly clocks.
    initial begin
        bus_t e;
        i_ack  = 1'b0;
        i_data = 32'h0;
        forever begin
            @(negedge clk);
            if (o_stb === 1'b1) begin
                if (exp_bus_q.size() == 0)
                    chk("unexpected_stb", {31'h0, o_stb}, 32'h0);
                else begin
                    e = exp_bus_q.pop_front();
                    chk("stb_addr", o_addr, e.addr);
                    chk("stb_we", {31'h0, o_we}, {31'h0, e.we});
                    chk("stb_data", o_data, e.data);
                end
                if (chk_busy) chk("busy_before_ack", {31'h0, o_busy}, 32'h1);
                for (int k = 0; k < ack_dly && o_stb === 1'b1; k++) @(negedge clk);
                if (o_stb === 1'b1) begin
                    i_data = rd_data;
                    i_ack  = 1'b1;
                    @(negedge clk);
                    i_ack  = 1'b0;
                    i_data = 32'h0;
                    ack_cnt++;
                    if (chk_busy) begin
                        repeat (2) @(negedge clk);
                        chk("busy_after_ack", {31'h0, o_busy}, 32'h0);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdat;
        int e0, a0;
        rst = 1'b0; cs = 1'b0; sck = 1'b0; mosi = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_miso", {31'h0, miso}, 32'h0);
        chk("rst_stb", {31'h0, o_stb}, 32'h0);
        chk("rst_we", {31'h0, o_we}, 32'h0);
        chk("rst_addr", o_addr, 32'h0);
        chk("rst_data", o_data, 32'h0);
        chk("rst_busy", {31'h0, o_busy}, 32'h0);
        chk("rst_err", {31'h0, o_err}, 32'h0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Plain read
        e0 = err_cnt; rd_data = 32'hCAFE_F00D; ack_dly = 2;
        exp_bus_q.push_back('{32'h8000_0010, 1'b0, 32'h0});
        exp_miso_q.push_back(32'hCAFE_F00D);
        frame(8'h03, 32'h8000_0010, 32'h0, 73, 1'b0, rdat);
        chk("t1_miso", rdat, exp_miso_q.pop_front());
        chk("t1_err", err_cnt - e0, 32'd0);
        chk("t1_idle_miso", {31'h0, miso}, 32'h0);
        chk("t1_busy", {31'h0, o_busy}, 32'h0);

        // Address miss
        e0 = err_cnt;
        exp_miso_q.push_back(32'h0);
        frame(8'h03, 32'h1234_0000, 32'h0, 73, 1'b0, rdat);
        chk("t2_miso", rdat, exp_miso_q.pop_front());
        chk("t2_err", err_cnt - e0, 32'd1);

        // Late ack
        e0 = err_cnt; a0 = ack_cnt; rd_data = 32'hDEAD_BEEF; ack_dly = 40; chk_busy = 1'b1;
        exp_bus_q.push_back('{32'h8000_0020, 1'b0, 32'h0});
        exp_miso_q.push_back(32'h0);
        frame(8'h03, 32'h8000_0020, 32'h0, 73, 1'b0, rdat);
        chk_busy = 1'b0;
        chk("t3_miso", rdat, exp_miso_q.pop_front());
        chk("t3_err", err_cnt - e0, 32'd1);
        chk("t3_acks", ack_cnt - a0, 32'd1);

        // Abort after 20 bits, then a full frame
        e0 = err_cnt; ack_dly = 2;
        frame(8'h03, 32'h8000_0020, 32'h0, 20, 1'b0, rdat);
        chk("t4_abort_err", err_cnt - e0, 32'd0);
        rd_data = 32'h1234_5678;
        exp_bus_q.push_back('{32'h8000_0030, 1'b0, 32'h0});
        exp_miso_q.push_back(32'h1234_5678);
        frame(8'h03, 32'h8000_0030, 32'h0, 73, 1'b0, rdat);
        chk("t4_miso", rdat, exp_miso_q.pop_front());

        // cs drop mid-data with o_stb high
        e0 = err_cnt; a0 = ack_cnt; ack_dly = 200;
        exp_bus_q.push_back('{32'h8000_0050, 1'b0, 32'h0});
        frame(8'h03, 32'h8000_0050, 32'h0, 45, 1'b0, rdat);
        chk("t4_stb_held", {31'h0, o_stb}, 32'h1);
        for (int i = 0; i < 400 && ack_cnt == a0; i++) @(negedge clk);
        chk("t4_ack_seen", ack_cnt - a0, 32'd1);
        @(negedge clk);
        chk("t4_stb_dropped", {31'h0, o_stb}, 32'h0);
        chk("t4_late_err", err_cnt - e0, 32'd1);

        // Write frame
        e0 = err_cnt; a0 = ack_cnt; ack_dly = 2;
`ifdef SPI_WRITE_EN
        exp_bus_q.push_back('{32'h8000_0004, 1'b1, 32'hA5A5_5A5A});
`endif
        frame(8'h02, 32'h8000_0004, 32'hA5A5_5A5A, 73, 1'b0, rdat);
`ifdef SPI_WRITE_EN
        chk("t5_err", err_cnt - e0, 32'd0);
        chk("t5_acks", ack_cnt - a0, 32'd1);
`else
        chk("t5_err", err_cnt - e0, 32'd1);
        chk("t5_acks", ack_cnt - a0, 32'd0);
`endif

        // Reset mid-read with o_stb high
        ack_dly = 300;
        exp_bus_q.push_back('{32'h8000_0060, 1'b0, 32'h0});
        frame(8'h03, 32'h8000_0060, 32'h0, 50, 1'b1, rdat);
        rst = 1'b0;
        #1;
        chk("t6_miso", {31'h0, miso}, 32'h0);
        chk("t6_stb", {31'h0, o_stb}, 32'h0);
        chk("t6_we", {31'h0, o_we}, 32'h0);
        chk("t6_addr", o_addr, 32'h0);
        chk("t6_data", o_data, 32'h0);
        chk("t6_busy", {31'h0, o_busy}, 32'h0);
        chk("t6_err", {31'h0, o_err}, 32'h0);
        @(negedge clk);
        cs = 1'b0; sck = 1'b0; mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        e0 = err_cnt; ack_dly = 2; rd_data = 32'h0F0F_1234;
        exp_bus_q.push_back('{32'h8000_0070, 1'b0, 32'h0});
        exp_miso_q.push_back(32'h0F0F_1234);
        frame(8'h03, 32'h8000_0070, 32'h0, 73, 1'b0, rdat);
        chk("t6_after_miso", rdat, exp_miso_q.pop_front());
        chk("t6_after_err", err_cnt - e0, 32'd0);

        repeat (10) @(negedge clk);
        chk("bus_q_empty", exp_bus_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
